// File: rtl/bp_be_spec_queue.sv
// bp_be_spec_queue
// FIFO with speculative reads. Reading an entry (yumi_i) does not free its
// slot. The slot is freed only when the read is committed (deq_i). roll_i
// rewinds the speculative read pointer to the committed one, so the consumer
// can replay entries it has read but not yet committed.
//
// Ports
//   clk_i    : clock; all state changes on the rising edge
//   reset_i  : asynchronous, active-high reset
//   clr_i    : synchronous flush of all entries
//   data_i   : enqueue data
//   v_i      : enqueue valid; ignored while ready_o is low
//   ready_o  : a free slot is available (from registered state only)
//   data_o   : entry at the speculative read pointer
//   v_o      : data_o holds an entry that has not been read yet
//   yumi_i   : consumer takes data_o (speculative read)
//   deq_i    : commit the oldest read entry and free its slot
//   roll_i   : rewind the speculative read pointer to the committed pointer
//   full_o   : no free slots
//   empty_o  : no entries held, committed or not
//   count_o  : entries held (wptr - cptr)
module bp_be_spec_queue #(
  parameter int width_p = 64,
  parameter int els_p   = 8,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [width_p-1:0]      data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  input  logic                    deq_i,
  input  logic                    roll_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [width_p-1:0]      mem [els_p];
  logic                    enq;

  // Each pointer has one more bit than the slot index needs. The extra bit
  // tells a full queue apart from an empty one when the slot indices match.
  // The pointers wrap on their own because els_p is a power of two.
  assign full_o  = (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]) &&
                   (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0]);
  assign empty_o = (wptr == cptr);
  assign ready_o = ~full_o;
  assign count_o = wptr - cptr;
  assign v_o     = (rptr != wptr);
  assign data_o  = mem[rptr[idx_width_lp-1:0]];

  assign enq = v_i & ready_o;

  always_comb begin
    wptr_n = wptr + ptr_width_lp'(enq);
    cptr_n = cptr + ptr_width_lp'(deq_i);
    // A roll lands on the committed pointer as it will be after this edge,
    // so a deq_i in the same cycle is included in the rewind.
    rptr_n = roll_i ? cptr_n : (rptr + ptr_width_lp'(yumi_i));
    if (clr_i) begin
      wptr_n = '0;
      rptr_n = '0;
      cptr_n = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  // The storage is not reset. An entry is visible only through the pointers.
  always_ff @(posedge clk_i) begin
    if (enq && !clr_i)
      mem[wptr[idx_width_lp-1:0]] <= data_i;
  end

`ifndef SYNTHESIS
  a_legal_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o)
    else $error("yumi_i asserted with v_o low");
  a_legal_deq: assert property (@(posedge clk_i) disable iff (reset_i)
    deq_i |-> (cptr != rptr))
    else $error("deq_i asserted with nothing read");
`endif

endmodule

// File: tb/tb_bp_be_spec_queue.sv
module tb_bp_be_spec_queue;

  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i, clr_i, v_i, yumi_i, deq_i, roll_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, full_o, empty_o;
  logic [W-1:0]  data_o;
  logic [PW-1:0] count_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model.
  // mq holds every entry that is still in the queue, oldest first.
  // rd_off counts how many of those entries have been read but not committed.
  logic [W-1:0] mq[$];
  int           rd_off = 0;

  bp_be_spec_queue #(.width_p(W), .els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .data_i(data_i),
    .v_i(v_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o),
    .yumi_i(yumi_i), .deq_i(deq_i), .roll_i(roll_i), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model. data_o is checked only while
  // the model says an unread entry is present.
  task automatic chk_outputs(input string tag);
    int  n = mq.size();
    logic mv = (rd_off < n);
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".full"},  32'(full_o),  32'(n == ELS));
    chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, ".ready"}, 32'(ready_o), 32'(n != ELS));
    chk({tag, ".v_o"},   32'(v_o),     32'(mv));
    if (mv) chk({tag, ".data"}, 32'(data_o), 32'(mq[rd_off]));
  endtask

  // Drive one cycle. Outputs are checked before the clock edge. The model is
  // updated at the edge, using the state from before the edge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic y, input logic dq, input logic rl,
                       input logic cl);
    logic acc;
    v_i = v; data_i = d; yumi_i = y; deq_i = dq; roll_i = rl; clr_i = cl;
    chk_outputs(tag);
    acc = v && (mq.size() < ELS);
    @(posedge clk_i);
    if (cl) begin
      mq.delete();
      rd_off = 0;
    end else begin
      if (y && !rl) rd_off++;
      if (dq) begin
        void'(mq.pop_front());
        rd_off--;
      end
      if (rl) rd_off = 0;
      if (acc) mq.push_back(d);
    end
    #1;
    v_i = 0; yumi_i = 0; deq_i = 0; roll_i = 0; clr_i = 0;
  endtask

  task automatic enq(input string tag, input logic [W-1:0] d);
    cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i = 1; clr_i = 0; v_i = 0; yumi_i = 0; deq_i = 0; roll_i = 0; data_i = '0;
    #2;
    chk_outputs("in_reset");
    @(posedge clk_i); #1;
    reset_i = 0;
    cycle("after_reset", 0, '0, 0, 0, 0, 0);

    // Fill the queue, try to enqueue into a full queue, then read in order.
    enq("fill0", 16'hA); enq("fill1", 16'hB); enq("fill2", 16'hC); enq("fill3", 16'hD);
    chk("fill.full_const", 32'(full_o), 32'd1);
    cycle("fifth_ignored", 1, 16'hE, 0, 0, 0, 0);
    for (int i = 0; i < ELS; i++) cycle("yumi_order", 0, '0, 1, 0, 0, 0);
    chk("yumi.v_after", 32'(v_o), 32'd0);
    for (int i = 0; i < ELS; i++) cycle("drain", 0, '0, 0, 1, 0, 0);

    // Read two, commit one, then roll back to the first uncommitted entry.
    enq("r_a", 16'hA); enq("r_b", 16'hB); enq("r_c", 16'hC);
    cycle("r_y1", 0, '0, 1, 0, 0, 0);
    cycle("r_y2", 0, '0, 1, 0, 0, 0);
    cycle("r_deq", 0, '0, 0, 1, 0, 0);
    cycle("r_roll", 0, '0, 0, 0, 1, 0);
    chk("roll.data", 32'(data_o), 32'hB);
    chk("roll.count", 32'(count_o), 32'd2);
    cycle("r_clr", 0, '0, 0, 0, 0, 1);

    // A deq_i does not free a slot for an enqueue in the same cycle.
    for (int i = 0; i < ELS; i++) enq("f_fill", 16'h10 + 16'(i));
    cycle("f_y", 0, '0, 1, 0, 0, 0);
    cycle("f_deq_enq", 1, 16'h99, 0, 1, 0, 0);
    chk("deq_enq.count", 32'(count_o), 32'd3);
    chk("deq_enq.ready", 32'(ready_o), 32'd1);
    cycle("f_clr", 0, '0, 0, 0, 0, 1);

    // roll_i, yumi_i and deq_i together with cptr=0, rptr=2: both end at 1.
    enq("s_0", 16'h20); enq("s_1", 16'h21); enq("s_2", 16'h22);
    cycle("s_y1", 0, '0, 1, 0, 0, 0);
    cycle("s_y2", 0, '0, 1, 0, 0, 0);
    cycle("s_all", 0, '0, 1, 1, 1, 0);
    chk("all3.data", 32'(data_o), 32'h21);
    chk("all3.count", 32'(count_o), 32'd2);
    cycle("s_clr", 0, '0, 0, 0, 0, 1);

    // Mixed enqueue, yumi and deq traffic that wraps the pointers several times.
    for (int i = 0; i < 12 * ELS; i++) begin
      logic v, y, dq;
      v  = ($urandom_range(0, 3) != 0);
      y  = (rd_off < mq.size()) && ($urandom_range(0, 1) == 1);
      dq = (rd_off > 0) && ($urandom_range(0, 2) != 0);
      cycle("wrap", v, W'($urandom), y, dq, 0, 0);
    end
    cycle("w_clr", 0, '0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a cycle with three entries held.
    enq("a_0", 16'h30); enq("a_1", 16'h31); enq("a_2", 16'h32);
    cycle("a_y", 0, '0, 1, 0, 0, 0);
    #3 reset_i = 1;
    #1;
    mq.delete(); rd_off = 0;
    chk_outputs("async_reset");
    @(posedge clk_i); #1;
    reset_i = 0;
    cycle("post_reset", 0, '0, 0, 0, 0, 0);

    // A synchronous flush with three entries held.
    enq("c_0", 16'h40); enq("c_1", 16'h41); enq("c_2", 16'h42);
    cycle("c_clr", 0, '0, 0, 0, 0, 1);
    chk("clr.empty", 32'(empty_o), 32'd1);
    cycle("c_after", 0, '0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_be_spec_queue.md
BP_BE_SPEC_QUEUE -- requirements
Module: bp_be_spec_queue

Interface
REQ-001 Parameters SHALL be: width_p, 64, entry width in bits; els_p, 8, queue depth (power of two, >= 2); ptr_width_lp, $clog2(els_p)+1, local pointer width including wrap bit.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_i  input  1  reset, asynchronous and active-high.
REQ-004 clr_i  input  1  synchronous flush of all entries.
REQ-005 data_i  input  width_p  enqueue data.
REQ-006 v_i  input  1  enqueue valid.
REQ-007 ready_o  output  1  queue can accept an enqueue this cycle.
REQ-008 data_o  output  width_p  entry at speculative read pointer.
REQ-009 v_o  output  1  data_o holds an unread entry.
REQ-010 yumi_i  input  1  consumer takes data_o (speculative read).
REQ-011 deq_i  input  1  commit oldest read-but-uncommitted entry; frees its slot.
REQ-012 roll_i  input  1  rewind speculative read pointer to committed pointer.
REQ-013 full_o  output  1  no free slots (committed view).
REQ-014 empty_o  output  1  no entries held, committed or not.
REQ-015 count_o  output  ptr_width_lp  entries held (wptr minus cptr).

Function
REQ-016 State SHALL be three ptr_width_lp pointers: wptr (write), rptr (speculative read), cptr (committed read), plus an els_p x width_p storage array.
REQ-017 Pointer increments SHALL wrap modulo 2*els_p; slot index = low $clog2(els_p) bits.
REQ-018 full_o SHALL be 1 when wptr and cptr differ only in the wrap bit; empty_o SHALL be 1 when wptr == cptr.
REQ-019 ready_o SHALL equal ~full_o, computed from registered state only (a same-cycle deq_i does not free a slot for enqueue).
REQ-020 Enqueue SHALL occur when v_i & ready_o: write data_i to slot wptr, increment wptr; v_i while ~ready_o SHALL be ignored.
REQ-021 v_o SHALL be 1 when rptr != wptr; data_o SHALL be storage[rptr] combinationally; entry enqueued in cycle N SHALL first appear on v_o/data_o in cycle N+1 (no bypass).
REQ-022 yumi_i SHALL be asserted only when v_o; on yumi_i rptr increments.
REQ-023 deq_i SHALL be asserted only when cptr != rptr; on deq_i cptr increments.
REQ-024 roll_i SHALL set rptr to the next-cycle value of cptr (cptr, or cptr+1 if deq_i same cycle) and SHALL override yumi_i in the same cycle.
REQ-025 Simultaneous enqueue, yumi_i and deq_i SHALL all take effect in one cycle.
REQ-026 clr_i SHALL set wptr, rptr, cptr to 0 next cycle, overriding enqueue, yumi_i, deq_i and roll_i; storage contents need not be cleared.
REQ-027 count_o SHALL equal (wptr - cptr) modulo 2*els_p, range 0..els_p.
REQ-028 Illegal yumi_i (v_o=0) or deq_i (cptr==rptr) SHALL be flagged by a simulation-only assertion; RTL behaviour then is don't-care.

Reset
REQ-029 Asserting reset_i SHALL asynchronously force wptr=rptr=cptr=0, independent of clk_i.
REQ-030 During and after reset until first enqueue: v_o=0, ready_o=1, full_o=0, empty_o=1, count_o=0; data_o undefined.
REQ-031 Reset asserted mid-operation SHALL discard all entries, including read-but-uncommitted ones; storage need not be reset.

Verification
REQ-032 els_p=4: enqueue 0xA,0xB,0xC,0xD back-to-back -> full_o=1, ready_o=0, count_o=4; fifth v_i ignored; yumi four times -> data_o A,B,C,D in order, v_o=0 after.
REQ-033 Enqueue A,B,C; yumi A,B; deq once; roll -> next cycle data_o=B, v_o=1, count_o=2.
REQ-034 Full queue, one entry read; same cycle deq_i and v_i=1 -> enqueue rejected, next cycle count_o=3, ready_o=1.
REQ-035 Same cycle roll_i, yumi_i and deq_i with cptr=0, rptr=2 -> next cycle cptr=1, rptr=1.
REQ-036 Run 3*els_p enqueue/yumi/deq cycles through wrap boundary -> data order preserved, full_o/empty_o correct at every wrap.
REQ-037 Assert reset_i asynchronously mid-cycle with 3 entries held -> outputs return to reset values before next clk_i edge; clr_i with 3 entries -> empty_o=1 next cycle.
